jtdd_vidmeas: RTL and testbench

- Video timing receiver/analyser for the JTDD video interface.
- Samples pixel-rate hs/vs/hbl/vbl on pxl_cen and recovers line and frame geometry: totals, active sizes and HS width.
- Reports lock when the geometry is stable over several frames.
- Used on the scaler/OSD side of the framework, and by verification, to confirm the raster produced by the timing generator.

---
 rtl/jtdd_vidmeas_pkg.sv | 33 +++
 rtl/jtdd_vidmeas_axis.sv | 81 ++++++++
 rtl/jtdd_vidmeas.sv | 182 ++++++++++++++++++
 tb/tb_jtdd_vidmeas.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtdd_vidmeas_pkg.sv
// Shared defaults and the geometry record for the JTDD video timing analyser.
package jtdd_vidmeas_pkg;

  localparam int HW_DEF    = 9;
  localparam int VW_DEF    = 9;
  localparam int WDW_DEF   = 10;
  localparam int LOCKN_DEF = 2;

  // Fields are wide enough for any supported HW/VW; narrower values are zero-extended.
  localparam int GW = 16;

  typedef struct packed {
    logic [GW-1:0] htotal;
    logic [GW-1:0] hact;
    logic [GW-1:0] vtotal;
    logic [GW-1:0] vact;
  } geom_t;

  function automatic geom_t geom_make(
    input logic [GW-1:0] ht,
    input logic [GW-1:0] ha,
    input logic [GW-1:0] vt,
    input logic [GW-1:0] va
  );
    geom_t g;
    g.htotal = ht;
    g.hact   = ha;
    g.vtotal = vt;
    g.vact   = va;
    return g;
  endfunction

endpackage

// File: rtl/jtdd_vidmeas_axis.sv
// Generic blank-driven axis measurer: counts positions from the blank falling
// edge and records total length and active length once armed.
module jtdd_vidmeas_axis #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_blank,
  input  logic         i_disarm,
  output logic         o_start,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_total,
  output logic [W-1:0] o_act,
  output logic         o_armed
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic         r_prev;
  logic         r_armed;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_total;
  logic [W-1:0] r_act;

  logic         w_start;
  logic         w_end;
  logic [W-1:0] w_cnt_p1;
  logic [W-1:0] w_cnt_inc;

  always_comb begin
    w_start  = i_en & r_prev & ~i_blank;
    w_end    = i_en & ~r_prev & i_blank;
    w_cnt_p1 = r_cnt + ONE;
    if (r_cnt == MAX) begin
      w_cnt_inc = r_cnt;
    end else begin
      w_cnt_inc = w_cnt_p1;
    end
  end

  // A fresh start re-arms even when a disarm request lands on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_total <= '0;
      r_act   <= '0;
    end else begin
      if (i_en) begin
        r_prev <= i_blank;
      end
      if (w_start) begin
        r_cnt <= '0;
        if (r_armed) begin
          r_total <= w_cnt_p1;
        end
        r_armed <= 1'b1;
      end else begin
        if (i_disarm) begin
          r_armed <= 1'b0;
        end
        if (i_en) begin
          if (w_end && r_armed) begin
            r_act <= w_cnt_p1;
          end
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign o_start = w_start;
  assign o_cnt   = r_cnt;
  assign o_total = r_total;
  assign o_act   = r_act;
  assign o_armed = r_armed;

endmodule

// File: rtl/jtdd_vidmeas.sv
// JTDD video timing analyser: recovers raster geometry from hs/vs/hbl/vbl
// and reports lock once the geometry repeats over several frames.
module jtdd_vidmeas
  import jtdd_vidmeas_pkg::*;
#(
  parameter int HW    = HW_DEF,
  parameter int VW    = VW_DEF,
  parameter int LOCKN = LOCKN_DEF,
  parameter int WDW   = WDW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          hs,
  input  logic          vs,
  input  logic          hbl,
  input  logic          vbl,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic [HW-1:0] htotal,
  output logic [HW-1:0] hact,
  output logic [HW-1:0] hs_len,
  output logic [VW-1:0] vtotal,
  output logic [VW-1:0] vact,
  output logic          frame_st,
  output logic          locked
);

  localparam logic [HW-1:0]  H_ONE    = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0]  H_MAX    = {HW{1'b1}};
  localparam logic [VW-1:0]  V_ONE    = {{(VW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0]  V_MAX    = {VW{1'b1}};
  localparam logic [WDW-1:0] WD_ONE   = {{(WDW-1){1'b0}}, 1'b1};
  localparam logic [WDW-1:0] WD_MAX   = {WDW{1'b1}};
  localparam logic [2:0]     LOCK_TGT = 3'(LOCKN);

  logic           w_ls;
  logic           w_fst;
  logic           w_v_en;
  logic           w_h_armed;
  logic           w_v_armed;
  logic           w_wd_trip;
  logic           w_hs_rise;
  logic           w_hs_fall;
  logic           w_vs_rise;
  logic           w_match;
  logic [VW-1:0]  w_vtot_meas;
  geom_t          w_cur;
  logic [2:0]     w_mc_nx;
  logic           w_lock_nx;

  logic           r_hs_prev;
  logic           r_vs_prev;
  logic           r_vs_seen;
  logic [HW-1:0]  r_hs_cnt;
  logic [HW-1:0]  r_hs_len;
  logic [WDW-1:0] r_wd;
  logic [2:0]     r_mc;
  logic           r_locked;
  logic           r_frame_st;
  geom_t          r_snap;

  assign w_v_en = pxl_cen & w_ls;

  jtdd_vidmeas_axis #(.W(HW)) u_haxis (
    .clk      (clk),
    .rst      (rst),
    .i_en     (pxl_cen),
    .i_blank  (hbl),
    .i_disarm (w_wd_trip),
    .o_start  (w_ls),
    .o_cnt    (hcnt),
    .o_total  (htotal),
    .o_act    (hact),
    .o_armed  (w_h_armed)
  );

  // Vertical axis advances once per line start, using vbl as seen at line starts.
  jtdd_vidmeas_axis #(.W(VW)) u_vaxis (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_v_en),
    .i_blank  (vbl),
    .i_disarm (w_wd_trip),
    .o_start  (w_fst),
    .o_cnt    (vcnt),
    .o_total  (vtotal),
    .o_act    (vact),
    .o_armed  (w_v_armed)
  );

  always_comb begin
    w_hs_rise = pxl_cen & hs & ~r_hs_prev;
    w_hs_fall = pxl_cen & ~hs & r_hs_prev;
    w_vs_rise = pxl_cen & vs & ~r_vs_prev;
    w_wd_trip = (r_wd == WD_MAX);
    if (w_v_armed) begin
      w_vtot_meas = vcnt + V_ONE;
    end else begin
      w_vtot_meas = vtotal;
    end
    w_cur   = geom_make(GW'(htotal), GW'(hact), GW'(w_vtot_meas), GW'(vact));
    w_match = (w_cur == r_snap) && (r_vs_seen || w_vs_rise);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
      r_hs_cnt  <= '0;
      r_hs_len  <= '0;
      r_wd      <= '0;
    end else if (pxl_cen) begin
      r_hs_prev <= hs;
      r_vs_prev <= vs;
      if (w_hs_rise) begin
        r_hs_cnt <= H_ONE;
      end else if (hs && (r_hs_cnt != H_MAX)) begin
        r_hs_cnt <= r_hs_cnt + H_ONE;
      end
      if (w_hs_fall && w_h_armed) begin
        r_hs_len <= r_hs_cnt;
      end
      if (w_ls) begin
        r_wd <= '0;
      end else if (!w_wd_trip) begin
        r_wd <= r_wd + WD_ONE;
      end
    end
  end

  // Only frame starts that close a measured frame may advance or break lock.
  always_comb begin
    w_mc_nx   = r_mc;
    w_lock_nx = r_locked;
    if (w_wd_trip) begin
      w_mc_nx   = 3'd0;
      w_lock_nx = 1'b0;
    end else if (w_fst && w_v_armed) begin
      if (w_match) begin
        if (r_mc >= LOCK_TGT) begin
          w_mc_nx = LOCK_TGT;
        end else begin
          w_mc_nx = r_mc + 3'd1;
        end
        w_lock_nx = (w_mc_nx == LOCK_TGT);
      end else begin
        w_mc_nx   = 3'd0;
        w_lock_nx = 1'b0;
      end
    end else if (vcnt == V_MAX) begin
      w_lock_nx = 1'b0;
    end else begin
      w_mc_nx = r_mc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_seen  <= 1'b0;
      r_mc       <= 3'd0;
      r_locked   <= 1'b0;
      r_frame_st <= 1'b0;
      r_snap     <= '0;
    end else begin
      r_mc       <= w_mc_nx;
      r_locked   <= w_lock_nx;
      r_frame_st <= w_fst;
      if (w_fst) begin
        r_snap    <= w_cur;
        r_vs_seen <= 1'b0;
      end else if (w_vs_rise) begin
        r_vs_seen <= 1'b1;
      end
    end
  end

  assign hs_len   = r_hs_len;
  assign frame_st = r_frame_st;
  assign locked   = r_locked;

endmodule

// File: tb/tb_jtdd_vidmeas.sv
// Self-checking bench for jtdd_vidmeas: scripted raster rows, watchdog and
// reset sequences, then randomized rasters checked against a frame-level model.
module tb_jtdd_vidmeas;

  localparam int LOCKN = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pxl_cen;
  logic       hs;
  logic       vs;
  logic       hbl;
  logic       vbl;
  logic [8:0] hcnt;
  logic [8:0] vcnt;
  logic [8:0] htotal;
  logic [8:0] hact;
  logic [8:0] hs_len;
  logic [8:0] vtotal;
  logic [8:0] vact;
  logic       frame_st;
  logic       locked;

  jtdd_vidmeas #(.HW(9), .VW(9), .LOCKN(LOCKN), .WDW(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .hs       (hs),
    .vs       (vs),
    .hbl      (hbl),
    .vbl      (vbl),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .htotal   (htotal),
    .hact     (hact),
    .hs_len   (hs_len),
    .vtotal   (vtotal),
    .vact     (vact),
    .frame_st (frame_st),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int htot;
    int hact;
    int hsw;
    int vtot;
    int vact;
  } geo_t;

  typedef struct {
    geo_t g;
    bit   vs_en;
    int   div;
    int   nfr;
    bit   exp_locked;
  } row_t;

  int   n_chk   = 0;
  int   n_pass  = 0;
  int   cen_div = 1;
  int   fst_cnt = 0;
  int   k;
  geo_t geo_q[$];
  bit   vs_q[$];

  always @(posedge clk) begin
    if (frame_st) fst_cnt <= fst_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input bit b_h, input bit b_v, input bit s_h, input bit s_v);
    hbl = b_h; vbl = b_v; hs = s_h; vs = s_v;
    pxl_cen = 1'b1;
    tick();
    for (int i = 1; i < cen_div; i++) begin
      pxl_cen = 1'b0;
      tick();
    end
  endtask

  task automatic drive_part(input geo_t g, input bit vb, input bit sv, input int p0, input int p1);
    for (int p = p0; p < p1; p++)
      pix(p >= g.hact, vb, (p >= g.hact + 2) && (p < g.hact + 2 + g.hsw), sv);
  endtask

  task automatic drive_line(input geo_t g, input bit vb, input bit sv);
    drive_part(g, vb, sv, 0, g.htot);
  endtask

  function automatic bit same_geo(input geo_t a, input geo_t b);
    return (a.htot == b.htot) && (a.hact == b.hact) && (a.vtot == b.vtot) && (a.vact == b.vact);
  endfunction

  // Locked after frame start kk: the last LOCKN closed frames each repeat
  // the one before and carried a vs pulse; the first measured frame never counts.
  function automatic bit model_locked(input int kk);
    if (kk < LOCKN + 2) return 1'b0;
    for (int i = 0; i < LOCKN; i++)
      if (!same_geo(geo_q[kk-1-i], geo_q[kk-2-i]) || !vs_q[kk-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic epoch_start();
    geo_t z;
    z = '{0, 0, 0, 0, 0};
    geo_q.delete();
    vs_q.delete();
    geo_q.push_back(z);
    vs_q.push_back(1'b0);
    k = 0;
  endtask

  task automatic drive_frame(input geo_t g, input bit vs_en);
    int f0;
    k++;
    geo_q.push_back(g);
    vs_q.push_back(vs_en);
    f0 = fst_cnt;
    for (int l = 0; l < g.vtot; l++) begin
      drive_line(g, l >= g.vact, vs_en && (l >= g.vact + 2) && (l < g.vact + 4));
      if (l == 0) chk("locked at frame start", int'(locked), int'(model_locked(k)));
    end
    chk("frame_st cycles per frame", fst_cnt - f0, 1);
    chk("hcnt end of frame", int'(hcnt), g.htot - 1);
    chk("vcnt end of frame", int'(vcnt), g.vtot - 1);
    chk("htotal", int'(htotal), g.htot);
    chk("hact", int'(hact), g.hact);
    chk("hs_len", int'(hs_len), g.hsw);
    chk("vact", int'(vact), g.vact);
    if (k >= 2) chk("vtotal", int'(vtotal), geo_q[k-1].vtot);
  endtask

  function automatic geo_t rand_geo();
    geo_t g;
    g.htot = $urandom_range(24, 64);
    g.hsw  = $urandom_range(1, 8);
    g.hact = $urandom_range(8, g.htot - g.hsw - 4);
    g.vtot = $urandom_range(12, 20);
    g.vact = $urandom_range(4, g.vtot - 6);
    return g;
  endfunction

  row_t rows[9];
  geo_t g0;
  geo_t g1;
  geo_t g40;
  geo_t cur;
  bit   ven;

  initial begin
    g0  = '{48, 32, 5, 20, 14};
    g1  = '{48, 32, 5, 21, 14};
    g40 = '{40, 24, 4, 20, 14};
    rows[0] = '{g0, 1'b1, 1, 3, 1'b0};
    rows[1] = '{g0, 1'b1, 1, 2, 1'b1};
    rows[2] = '{g1, 1'b1, 1, 1, 1'b1};
    rows[3] = '{g0, 1'b1, 1, 1, 1'b0};
    rows[4] = '{g0, 1'b1, 1, 3, 1'b1};
    rows[5] = '{g0, 1'b1, 3, 2, 1'b1};
    rows[6] = '{g0, 1'b0, 3, 1, 1'b1};
    rows[7] = '{g0, 1'b1, 1, 1, 1'b0};
    rows[8] = '{g0, 1'b1, 1, 3, 1'b1};

    rst = 1'b1; pxl_cen = 1'b0; hs = 1'b0; vs = 1'b0; hbl = 1'b0; vbl = 1'b0;
    repeat (3) tick();
    chk("reset htotal", int'(htotal), 0);
    chk("reset vtotal", int'(vtotal), 0);
    chk("reset hs_len", int'(hs_len), 0);
    chk("reset locked", int'(locked), 0);
    chk("reset frame_st", int'(frame_st), 0);
    rst = 1'b0;
    tick();

    // Scripted rows on one continuous raster.
    epoch_start();
    repeat (3) drive_line(g0, 1'b1, 1'b0);
    for (int r = 0; r < 9; r++) begin
      cen_div = rows[r].div;
      for (int f = 0; f < rows[r].nfr; f++) drive_frame(rows[r].g, rows[r].vs_en);
      chk($sformatf("row %0d locked", r), int'(locked), int'(rows[r].exp_locked));
    end

    // Watchdog: no line start for longer than the timeout.
    cen_div = 1;
    for (int i = 0; i < 1100; i++) pix(1'b1, 1'b1, 1'b0, 1'b0);
    chk("watchdog locked", int'(locked), 0);
    chk("watchdog htotal hold", int'(htotal), 48);
    chk("watchdog hact hold", int'(hact), 32);
    chk("watchdog vtotal hold", int'(vtotal), 20);
    chk("watchdog vact hold", int'(vact), 14);
    drive_line(g40, 1'b1, 1'b0);
    chk("htotal after rearm ls", int'(htotal), 48);
    drive_line(g40, 1'b1, 1'b0);
    chk("htotal after second ls", int'(htotal), 40);

    // Reset mid-line.
    drive_part(g40, 1'b1, 1'b0, 0, 10);
    rst = 1'b1;
    #1;
    chk("mid-line reset htotal", int'(htotal), 0);
    chk("mid-line reset hact", int'(hact), 0);
    chk("mid-line reset vtotal", int'(vtotal), 0);
    chk("mid-line reset vact", int'(vact), 0);
    chk("mid-line reset hcnt", int'(hcnt), 0);
    chk("mid-line reset hs_len", int'(hs_len), 0);
    tick();
    tick();
    rst = 1'b0;
    drive_part(g40, 1'b1, 1'b0, 10, 40);
    drive_line(g40, 1'b1, 1'b0);
    chk("htotal after first ls post reset", int'(htotal), 0);
    drive_line(g40, 1'b1, 1'b0);
    chk("htotal after second ls post reset", int'(htotal), 40);

    // Randomized rasters against the frame-level model.
    epoch_start();
    cur = rand_geo();
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 3) == 0) cur = rand_geo();
      ven = ($urandom_range(0, 7) != 0);
      cen_div = $urandom_range(1, 2);
      drive_frame(cur, ven);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
